// File: rtl/acmp_pkg.sv
// acmp_pkg: shared types and helpers for the ACMP vote controller.
//   acmp_state_e : FSM state encoding shared by the top and the vote engine
//   vote_w()     : width that holds a vote count 0..VOTES without wrapping
//   trim_mid()   : mid-scale offset-trim code for a given trim width
package acmp_pkg;

  typedef enum logic [2:0] {IDLE, EVAL, PRE, DONE, CAL} acmp_state_e;

  function automatic int vote_w(input int votes);
    return $clog2(votes + 1);
  endfunction

  function automatic logic [7:0] trim_mid(input int trim_w);
    return 8'd1 << (trim_w - 1);
  endfunction

endpackage

// File: rtl/acmp_vote_ctrl_if.sv
// acmp_vote_ctrl_if: SAR-controller side handshake of the ACMP vote controller.
//   start/cal_start : requests from the SAR controller
//   busy/done       : request status, done is a 1-cycle pulse
//   result/margin   : majority bit and number of votes that returned 1
//   cal_short       : input-mux short command during offset calibration
//   cal_done        : 1-cycle pulse at the end of calibration
// master = SAR controller, slave = acmp_vote_ctrl.
interface acmp_vote_ctrl_if #(parameter int VOTES = 3);
  import acmp_pkg::*;

  localparam int MW = vote_w(VOTES);

  logic          start;
  logic          busy;
  logic          done;
  logic          result;
  logic [MW-1:0] margin;
  logic          cal_start;
  logic          cal_short;
  logic          cal_done;

  modport master (
    output start, cal_start,
    input  busy, done, result, margin, cal_short, cal_done
  );

  modport slave (
    input  start, cal_start,
    output busy, done, result, margin, cal_short, cal_done
  );

endinterface

// File: rtl/acmp_vote_seq.sv
// acmp_vote_seq: comparator strobe / vote / majority engine.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   go_i         : start a request; taken in IDLE and in DONE (back-to-back)
//   busy_o       : engine not idle
//   done_o       : 1-cycle pulse, result_o/ones_o valid
//   result_o     : majority of the votes taken
//   ones_o       : number of votes that returned 1
//   cmp_clk_o    : comparator clock, registered (1 = evaluate)
//   cmp_q_i      : comparator output
//
// state | meaning
// IDLE  | waiting for go_i
// EVAL  | cmp_clk high, SETTLE+1 cycles; cmp_q captured on the last edge
// PRE   | cmp_clk low (precharge); decides next vote or finish
// DONE  | result valid, done pulse
module acmp_vote_seq
  import acmp_pkg::*;
#(
  parameter int VOTES      = 3,
  parameter int SETTLE     = 1,
  parameter int EARLY_EXIT = 0,
  localparam int MW        = vote_w(VOTES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          go_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          result_o,
  output logic [MW-1:0] ones_o,
  output logic          cmp_clk_o,
  input  logic          cmp_q_i
);

  localparam logic [MW-1:0] VOTES_C = MW'(VOTES);
  localparam logic [MW-1:0] HALF    = MW'(VOTES / 2);

  acmp_state_e   state_q, state_d;
  logic [2:0]    settle_q, settle_d;
  logic [MW-1:0] left_q, left_d;
  logic [MW-1:0] ones_q, ones_d;
  logic          result_q, result_d;
  logic          cmp_clk_q;
  logic [MW-1:0] zeros;
  logic          decided;

  assign zeros   = (VOTES_C - left_q) - ones_q;
  assign decided = (EARLY_EXIT != 0) && ((ones_q > HALF) || (zeros > HALF));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    left_d   = left_q;
    ones_d   = ones_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (go_i) begin
          state_d  = EVAL;
          settle_d = 3'(SETTLE);
          left_d   = VOTES_C;
          ones_d   = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      EVAL: begin
        if (settle_q == 3'd0) begin
          state_d = PRE;
          left_d  = left_q - MW'(1);
          ones_d  = ones_q + MW'(cmp_q_i);
        end else begin
          settle_d = settle_q - 3'd1;
        end
      end
      PRE: begin
        if ((left_q == '0) || decided) begin
          state_d  = DONE;
          result_d = (ones_q > HALF);
        end else begin
          state_d  = EVAL;
          settle_d = 3'(SETTLE);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      settle_q  <= 3'd0;
      left_q    <= '0;
      ones_q    <= '0;
      result_q  <= 1'b0;
      cmp_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      left_q    <= left_d;
      ones_q    <= ones_d;
      result_q  <= result_d;
      // Registered from the next state so the strobe never glitches.
      cmp_clk_q <= (state_d == EVAL);
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign result_o  = result_q;
  assign ones_o    = ones_q;
  assign cmp_clk_o = cmp_clk_q;

endmodule

// File: rtl/acmp_vote_ctrl.sv
// acmp_vote_ctrl: ACMP comparator sequencer for the SAR ADC.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   bus          : acmp_vote_ctrl_if.slave (start/busy/done/result/margin, cal_*)
//   cmp_clk_o    : comparator clock (1 = evaluate, 0 = precharge)
//   cmp_q_i      : comparator output
//   trim_o       : offset-trim code to the comparator DAC
// Build option ACMP_CAL_EN: enables the offset-trim SAR calibration. Without it
// cal_start is ignored, cal_short/cal_done stay 0 and trim is fixed at mid-scale.
//
// state | meaning
// IDLE  | waiting for start / cal_start
// EVAL  | external request running in the vote engine
// CAL   | calibration: one internal request per trim bit, inputs shorted
// DONE  | calibration finished, cal_done pulse
module acmp_vote_ctrl
  import acmp_pkg::*;
#(
  parameter int VOTES      = 3,
  parameter int SETTLE     = 1,
  parameter int TRIM_W     = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  acmp_vote_ctrl_if.slave   bus,
  output logic              cmp_clk_o,
  input  logic              cmp_q_i,
  output logic [TRIM_W-1:0] trim_o
);

  localparam int MW = vote_w(VOTES);
  localparam logic [TRIM_W-1:0] TRIM_MID = TRIM_W'(trim_mid(TRIM_W));

  acmp_state_e   state_q, state_d;
  logic          seq_go, seq_busy, seq_done, seq_result;
  logic [MW-1:0] seq_ones;

  acmp_vote_seq #(
    .VOTES     (VOTES),
    .SETTLE    (SETTLE),
    .EARLY_EXIT(EARLY_EXIT)
  ) u_seq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .go_i     (seq_go),
    .busy_o   (seq_busy),
    .done_o   (seq_done),
    .result_o (seq_result),
    .ones_o   (seq_ones),
    .cmp_clk_o(cmp_clk_o),
    .cmp_q_i  (cmp_q_i)
  );

`ifdef ACMP_CAL_EN
  localparam int BW = $clog2(TRIM_W);
  logic [TRIM_W-1:0] trim_q, trim_d, cur_mask;
  logic [BW-1:0]     bit_q, bit_d;

  assign cur_mask = TRIM_W'(1) << bit_q;
`else
  logic unused_cal;
  assign unused_cal = bus.cal_start;
`endif

  always_comb begin
    state_d = state_q;
    seq_go  = 1'b0;
`ifdef ACMP_CAL_EN
    trim_d  = trim_q;
    bit_d   = bit_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ACMP_CAL_EN
        if (bus.cal_start) begin
          state_d = CAL;
          trim_d  = '0;
          bit_d   = BW'(TRIM_W - 1);
        end else
`endif
        if (bus.start) begin
          state_d = EVAL;
          seq_go  = 1'b1;
        end
      end
      EVAL: if (seq_done) state_d = IDLE;
`ifdef ACMP_CAL_EN
      CAL: begin
        // First CAL cycle: engine still idle, set the MSB and launch.
        if (!seq_busy) begin
          trim_d = trim_q | cur_mask;
          seq_go = 1'b1;
        end else if (seq_done) begin
          // Comparator says INP > INN with the trial bit set: too much trim.
          if (seq_result) trim_d = trim_q & ~cur_mask;
          if (bit_q == '0) begin
            state_d = DONE;
          end else begin
            // Next trial bit is launched from the engine's DONE cycle.
            bit_d  = bit_q - BW'(1);
            trim_d = trim_d | (cur_mask >> 1);
            seq_go = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
`ifdef ACMP_CAL_EN
      trim_q  <= TRIM_MID;
      bit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ACMP_CAL_EN
      trim_q  <= trim_d;
      bit_q   <= bit_d;
`endif
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == EVAL) && seq_done;
  assign bus.result = seq_result;
  assign bus.margin = seq_ones;

`ifdef ACMP_CAL_EN
  assign bus.cal_short = (state_q == CAL);
  assign bus.cal_done  = (state_q == DONE);
  assign trim_o        = trim_q;
`else
  assign bus.cal_short = 1'b0;
  assign bus.cal_done  = 1'b0;
  assign trim_o        = TRIM_MID;
`endif

endmodule

// File: tb/tb_acmp_vote_ctrl.sv
// Bench for acmp_vote_ctrl: two instances (A: 3 votes, settle 1, full count;
// B: 5 votes, settle 2, early exit) driven by a vote-list comparator model.
module tb_acmp_vote_ctrl;

  localparam int VA = 3, SA = 1, EA = 0;
  localparam int VB = 5, SB = 2, EB = 1;
  localparam int TW = 4;
  localparam logic [TW-1:0] MID = 4'd8;
  localparam int CAL_LAT = TW * (VA * (SA + 2) + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acmp_vote_ctrl_if #(.VOTES(VA)) ifa ();
  acmp_vote_ctrl_if #(.VOTES(VB)) ifb ();

  logic          cmp_clk_a, cmp_clk_b, cmp_q_a, cmp_q_b;
  logic [TW-1:0] trim_a, trim_b;

  acmp_vote_ctrl #(.VOTES(VA), .SETTLE(SA), .TRIM_W(TW), .EARLY_EXIT(EA)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa),
    .cmp_clk_o(cmp_clk_a), .cmp_q_i(cmp_q_a), .trim_o(trim_a)
  );

  acmp_vote_ctrl #(.VOTES(VB), .SETTLE(SB), .TRIM_W(TW), .EARLY_EXIT(EB)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb),
    .cmp_clk_o(cmp_clk_b), .cmp_q_i(cmp_q_b), .trim_o(trim_b)
  );

  // Comparator model: vote i of a request answers vv[i]; votes are indexed by
  // falling cmp_clk edges since the request began. In cal mode the shorted
  // comparator with offset -3 answers (offset + trim > 8).
  logic [15:0] vv_a, vv_b;
  int          fall_a = 0, fall_b = 0;
  int          base_a, base_b;
  logic        cal_mode;

  always @(negedge cmp_clk_a) fall_a++;
  always @(negedge cmp_clk_b) fall_b++;

  assign cmp_q_a = cal_mode ? ((int'(trim_a) - 3) > 8) : vv_a[4'(fall_a - base_a)];
  assign cmp_q_b = vv_b[4'(fall_b - base_b)];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Majority rule: stop early once either side holds more than half.
  function automatic void ref_vote(input logic [15:0] v, input int n, input bit ee,
                                   output int taken, output int ones, output logic res);
    int zeros;
    ones = 0; zeros = 0; taken = 0;
    for (int i = 0; i < n; i++) begin
      if (v[i]) ones++; else zeros++;
      taken++;
      if (ee && (ones > n / 2 || zeros > n / 2)) break;
    end
    res = (ones > n / 2);
  endfunction

  // Binary search on the trim code against the shorted-input comparator.
  function automatic int ref_cal();
    int t = 0;
    for (int b = TW - 1; b >= 0; b--) begin
      t = t | (1 << b);
      if ((t - 3) > 8) t = t & ~(1 << b);
    end
    return t;
  endfunction

  function automatic logic busy_of(input int d);
    return (d != 0) ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic done_of(input int d);
    return (d != 0) ? ifb.done : ifa.done;
  endfunction
  function automatic logic result_of(input int d);
    return (d != 0) ? ifb.result : ifa.result;
  endfunction
  function automatic logic [31:0] margin_of(input int d);
    return (d != 0) ? 32'(ifb.margin) : 32'(ifa.margin);
  endfunction

  task automatic req(input int d, input logic [15:0] v, input bit chk_clk,
                     input bit hold, input bit with_cal);
    int n, s, taken, ones, lat, k;
    bit ee;
    logic res;
    n  = (d == 0) ? VA : VB;
    s  = (d == 0) ? SA : SB;
    ee = (d == 0) ? (EA != 0) : (EB != 0);
    ref_vote(v, n, ee, taken, ones, res);
    lat = taken * (s + 2);
    if (d == 0) begin
      vv_a = v; base_a = fall_a; ifa.start = 1'b1; ifa.cal_start = with_cal;
    end else begin
      vv_b = v; base_b = fall_b; ifb.start = 1'b1;
    end
    step();
    ifa.cal_start = 1'b0;
    if (!hold) begin ifa.start = 1'b0; ifb.start = 1'b0; end
    check("busy_accept", busy_of(d), 1'b1);
    k = 0;
    while (done_of(d) !== 1'b1 && k < 200) begin
      if (chk_clk) check("cmp_clk_pat", cmp_clk_a, ((k % (s + 2)) < (s + 1)));
      step();
      k++;
    end
    check("done_lat", k, lat);
    check("result", result_of(d), res);
    check("margin", margin_of(d), ones);
    check("busy_at_done", busy_of(d), 1'b1);
    step();
    check("busy_after", busy_of(d), 1'b0);
    check("done_pulse", done_of(d), 1'b0);
    if (hold) begin
      ifa.start = 1'b0; ifb.start = 1'b0;
      step();
      check("hold_no_requeue", busy_of(d), 1'b0);
    end
  endtask

  task automatic run_cal(input bit with_start);
    int k, ndone;
    bit bad_short;
    cal_mode = 1'b1;
    ifa.cal_start = 1'b1;
    ifa.start     = with_start;
    step();
    ifa.cal_start = 1'b0;
    ifa.start     = 1'b0;
    k = 0; ndone = 0; bad_short = 1'b0;
    while (ifa.cal_done !== 1'b1 && k < 100) begin
      if (ifa.cal_short !== 1'b1) bad_short = 1'b1;
      if (ifa.done === 1'b1) ndone++;
      step();
      k++;
    end
    check("cal_lat", k, CAL_LAT);
    check("cal_short_hold", bad_short, 1'b0);
    check("cal_no_done", ndone, 0);
    check("cal_trim", trim_a, ref_cal());
    check("cal_short_end", ifa.cal_short, 1'b0);
    step();
    check("cal_done_pulse", ifa.cal_done, 1'b0);
    check("cal_busy_end", ifa.busy, 1'b0);
    check("cal_trim_hold", trim_a, ref_cal());
    cal_mode = 1'b0;
  endtask

  logic [31:0] rnd;
  bit          bad;
  int          nd;

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.cal_start = 1'b0;
    ifb.start = 1'b0; ifb.cal_start = 1'b0;
    cal_mode = 1'b0; vv_a = '0; vv_b = '0; base_a = 0; base_b = 0;
    repeat (3) step();

    check("rst_busy", ifa.busy, 1'b0);
    check("rst_done", ifa.done, 1'b0);
    check("rst_result", ifa.result, 1'b0);
    check("rst_margin", margin_of(0), 0);
    check("rst_cmp_clk", cmp_clk_a, 1'b0);
    check("rst_trim", trim_a, MID);
    check("rst_cal_short", ifa.cal_short, 1'b0);
    check("rst_cal_done", ifa.cal_done, 1'b0);
    check("rst_busy_b", ifb.busy, 1'b0);
    check("rst_trim_b", trim_b, MID);
    rst = 1'b0;
    step();

    // all ones, strobe pattern 1,1,0 per vote
    req(0, 16'h0007, 1'b1, 1'b0, 1'b0);
    // 5 votes 1,0,1,0,0 and early exit on 1,1,1
    req(1, 16'h0005, 1'b0, 1'b0, 1'b0);
    req(1, 16'h0007, 1'b0, 1'b0, 1'b0);
    req(1, 16'h0018, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rnd = $urandom;
      req(i % 2, rnd[15:0], 1'b0, 1'b0, 1'b0);
    end
    // start held through the whole request
    req(0, 16'h0002, 1'b0, 1'b1, 1'b0);
    req(1, 16'h001b, 1'b0, 1'b1, 1'b0);

`ifdef ACMP_CAL_EN
    run_cal(1'b1);
    run_cal(1'b0);
    req(0, 16'h0006, 1'b0, 1'b0, 1'b0);
    check("trim_after_req", trim_a, ref_cal());
`else
    ifa.cal_start = 1'b1;
    step();
    ifa.cal_start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ({ifa.busy, ifa.cal_done, ifa.cal_short, cmp_clk_a} !== 4'b0) bad = 1'b1;
      step();
    end
    check("nocal_idle", bad, 1'b0);
    check("nocal_trim", trim_a, MID);
    // cal_start ignored, start alongside it runs a normal request
    req(0, 16'h0005, 1'b0, 1'b0, 1'b1);
`endif

    // reset in the second EVAL cycle after a result=1 request
    req(0, 16'h0007, 1'b0, 1'b0, 1'b0);
    vv_a = 16'h0007; base_a = fall_a; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    step();
    check("pre_rst_cmp_clk", cmp_clk_a, 1'b1);
    rst = 1'b1;
    step();
    check("abort_cmp_clk", cmp_clk_a, 1'b0);
    check("abort_busy", ifa.busy, 1'b0);
    check("abort_trim", trim_a, MID);
    check("abort_result", ifa.result, 1'b0);
    check("abort_margin", margin_of(0), 0);
    check("abort_cal_short", ifa.cal_short, 1'b0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.done !== 1'b0) nd++;
      step();
    end
    check("abort_no_done", nd, 0);
    check("abort_idle", ifa.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
